nibble_serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the combinational nibble adder: adds two NIBBLES×4-bit operands one nibble per clock.
- Two modes: chained (full-width add, carry ripples nibble to nibble) and lane-independent (each nibble pair summed separately into a 5-bit lane).
- Start/busy/done handshake; operands latched at start. Sits between register-file operand sources and the result display/checker path.

---
 rtl/nibble_pkg.sv | 23 ++
 rtl/nibble_serial_adder_add4.sv | 17 +
 rtl/nibble_serial_adder.sv | 129 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_pkg
//  Description : Shared widths, FSM state encoding and mode constants for the
//                nibble-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_pkg;

    localparam int NIBBLE_W = 4;
    localparam int LANE_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_CHAIN = 1'b0;
    localparam logic MODE_LANE  = 1'b1;

endpackage : nibble_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_add4.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add4
//  Description : 4-bit adder with carry-in producing a 5-bit sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] s
);

    assign s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule : nibble_add4
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Adds two NIBBLES x 4-bit operands one nibble per clock, either
//                as one chained add or as independent 5-bit lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   ctrl,
    output logic                   busy,
    output logic                   done,
    output logic [5*NIBBLES-1:0]   q
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int QW    = LANE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               mode_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [QW-1:0]      q_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic               w_cin;
    logic [4:0]         w_sum;

    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Lane mode never sees a carry-in, so each lane is a standalone 5-bit sum.
    assign w_cin = (mode_q == MODE_CHAIN) & carry_q;

    nibble_add4 u_add4 (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .cin (w_cin),
        .s   (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_CHAIN;
            carry_q <= 1'b0;
            idx_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        mode_q  <= ctrl;
                        q_q     <= '0;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            if (mode_q == MODE_CHAIN)
                                q_q[i*NIBBLE_W +: NIBBLE_W] <= w_sum[3:0];
                            else
                                q_q[i*LANE_W +: LANE_W] <= w_sum;
                        end
                    end
                    if (mode_q == MODE_CHAIN)
                        carry_q <= w_sum[4];
                    if (idx_q == LAST_IDX) begin
                        if (mode_q == MODE_CHAIN)
                            q_q[W] <= w_sum[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Scoreboard bench for nibble_serial_adder with NIBBLES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int N  = 2;
    localparam int W  = 4 * N;
    localparam int QW = 5 * N;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ctrl  = 1'b0;
    logic [W-1:0]  A     = '0;
    logic [W-1:0]  B     = '0;
    logic          busy;
    logic          done;
    logic [QW-1:0] q;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ctrl  (ctrl),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [QW-1:0] q;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          m_e;
    logic [QW-1:0] last_exp;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [QW-1:0] ref_model(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic m);
        logic [QW-1:0] r;
        logic [3:0]    an;
        logic [3:0]    bn;
        r = '0;
        if (!m) begin
            r = QW'(a) + QW'(b);
        end else begin
            for (int i = 0; i < N; i++) begin
                an = a[i*4 +: 4];
                bn = b[i*4 +: 4];
                r[i*5 +: 5] = 5'(an) + 5'(bn);
            end
        end
        return r;
    endfunction

    task automatic check_v(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_i("unexpected_done", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check_v("result_q", q, m_e.q);
                check_i("done_cycle", cyc, m_e.due);
                check_v("busy_at_done", QW'(busy), '0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((busy || done) && n < 50);
        if (n >= 50) check_i("idle_timeout", n, 0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic hold);
        exp_t e;
        wait_idle();
        A     = a;
        B     = b;
        ctrl  = m;
        start = 1'b1;
        e.q   = ref_model(a, b, m);
        e.due = cyc + 1 + N;
        last_exp = e.q;
        sb.push_back(e);
        @(posedge clk);
        #2;
        if (!hold) start = 1'b0;
        check_v("busy_after_start", QW'(busy), QW'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_i("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #2;
        check_v("q_hold", q, last_exp);
    endtask

    initial begin
        logic hold;
        #3;
        check_v("reset_busy", QW'(busy), '0);
        check_v("reset_done", QW'(done), '0);
        check_v("reset_q", q, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        issue(8'h24, 8'h81, 1'b0, 1'b0); drain();
        issue(8'h0D, 8'h8D, 1'b0, 1'b0); drain();
        issue(8'hF9, 8'hC6, 1'b0, 1'b0); drain();
        issue(8'hF9, 8'hC6, 1'b1, 1'b0); drain();

        // Operands and start changed while the add is in flight.
        issue(8'h24, 8'h81, 1'b1, 1'b0);
        A     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        drain();
        repeat (6) @(posedge clk);

        // Abort one cycle into the operation.
        issue(8'h76, 8'h3D, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_v("abort_busy", QW'(busy), '0);
        check_v("abort_done", QW'(done), '0);
        check_v("abort_q", q, '0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        issue(8'h65, 8'h12, 1'b0, 1'b0); drain();

        for (int i = 0; i < 24; i++) begin
            hold = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        start = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire
